// File: rtl/i_mem_fetch_sched.sv
// i_mem_fetch_sched
//   Round-robin instruction fetch scheduler for four hardware threads sharing
//   one instruction memory read port with a single cycle of read latency.
//   Each thread owns a PC and may have at most one fetch outstanding. The
//   outstanding fetch retires when the pipeline returns that thread's next PC.
//
// Ports
//   QClk              in   clock, rising edge
//   RstQnnnL          in   asynchronous active-low reset
//   ThreadEnQ100H     in   [3:0] per-thread enable
//   ThreadStallQ100H  in   [3:0] per-thread fetch block for this cycle
//   FetchHoldQ100H    in   global fetch block for this cycle
//   NextPcValidQ102H  in   PC update valid
//   NextPcThreadQ102H in   [1:0] thread receiving the PC update
//   NextPcQ102H       in   [31:0] new PC; bits [1:0] are dropped
//   PcQ100H           out  [31:0] fetch address, 0 when idle
//   RdEnableQ100H     out  fetch read enable
//   FetchThreadQ100H  out  [1:0] granted thread, 0 when idle
//   InstValidQ101H    out  memory output holds a fetched instruction
//   InstThreadQ101H   out  [1:0] owner of that instruction
//   InstPcQ101H       out  [31:0] PC of that instruction
//   FetchCntQ101H     out  [31:0] free-running count of issued fetches
module i_mem_fetch_sched #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STRIDE = 32'h0000_0400
) (
    input  logic        QClk,
    input  logic        RstQnnnL,
    input  logic [3:0]  ThreadEnQ100H,
    input  logic [3:0]  ThreadStallQ100H,
    input  logic        FetchHoldQ100H,
    input  logic        NextPcValidQ102H,
    input  logic [1:0]  NextPcThreadQ102H,
    input  logic [31:0] NextPcQ102H,
    output logic [31:0] PcQ100H,
    output logic        RdEnableQ100H,
    output logic [1:0]  FetchThreadQ100H,
    output logic        InstValidQ101H,
    output logic [1:0]  InstThreadQ101H,
    output logic [31:0] InstPcQ101H,
    output logic [31:0] FetchCntQ101H
);

    logic [31:0] pc [4];
    logic [3:0]  in_flight;
    logic [3:0]  in_flight_nxt;
    logic [1:0]  last_gnt;
    logic [3:0]  eligible;
    logic        gnt_valid;
    logic [1:0]  gnt_id;
    logic [1:0]  cand;
    logic        inst_valid;
    logic [1:0]  inst_thread;
    logic [31:0] inst_pc;
    logic [31:0] fetch_cnt;

    // Word alignment drops the two LSBs of the returned PC.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^NextPcQ102H[1:0];

    // Grant search starts one past the last winner; uses pre-update state.
    always_comb begin
        eligible  = ThreadEnQ100H & ~ThreadStallQ100H & ~in_flight
                    & {4{~FetchHoldQ100H}};
        gnt_valid = 1'b0;
        gnt_id    = 2'd0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_gnt + 2'(k);
            if (!gnt_valid && eligible[cand]) begin
                gnt_valid = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    // Disable beats everything; an update and a grant never hit the same thread.
    always_comb begin
        in_flight_nxt = in_flight;
        for (int i = 0; i < 4; i++) begin
            if (!ThreadEnQ100H[i]) begin
                in_flight_nxt[i] = 1'b0;
            end else if (NextPcValidQ102H && (NextPcThreadQ102H == 2'(i))) begin
                in_flight_nxt[i] = 1'b0;
            end else if (RdEnableQ100H && (gnt_id == 2'(i))) begin
                in_flight_nxt[i] = 1'b1;
            end
        end
    end

    // Q100H outputs are forced idle while reset is asserted.
    always_comb begin
        RdEnableQ100H    = gnt_valid & RstQnnnL;
        FetchThreadQ100H = RdEnableQ100H ? gnt_id : 2'd0;
        PcQ100H          = RdEnableQ100H ? pc[gnt_id] : 32'd0;
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            for (int i = 0; i < 4; i++) begin
                pc[i] <= (RESET_PC + 32'(i) * PC_STRIDE) & ~32'h3;
            end
            in_flight   <= 4'd0;
            last_gnt    <= 2'd3;
            inst_valid  <= 1'b0;
            inst_thread <= 2'd0;
            inst_pc     <= 32'd0;
            fetch_cnt   <= 32'd0;
        end else begin
            if (NextPcValidQ102H) begin
                pc[NextPcThreadQ102H] <= {NextPcQ102H[31:2], 2'b00};
            end
            in_flight   <= in_flight_nxt;
            if (RdEnableQ100H) begin
                last_gnt  <= gnt_id;
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            inst_valid  <= RdEnableQ100H;
            inst_thread <= FetchThreadQ100H;
            inst_pc     <= PcQ100H;
        end
    end

    assign InstValidQ101H  = inst_valid;
    assign InstThreadQ101H = inst_thread;
    assign InstPcQ101H     = inst_pc;
    assign FetchCntQ101H   = fetch_cnt;

endmodule

// File: tb/tb_i_mem_fetch_sched.sv
module tb_i_mem_fetch_sched;

    logic        QClk = 1'b0;
    logic        RstQnnnL;
    logic [3:0]  ThreadEnQ100H;
    logic [3:0]  ThreadStallQ100H;
    logic        FetchHoldQ100H;
    logic        NextPcValidQ102H;
    logic [1:0]  NextPcThreadQ102H;
    logic [31:0] NextPcQ102H;
    logic [31:0] PcQ100H;
    logic        RdEnableQ100H;
    logic [1:0]  FetchThreadQ100H;
    logic        InstValidQ101H;
    logic [1:0]  InstThreadQ101H;
    logic [31:0] InstPcQ101H;
    logic [31:0] FetchCntQ101H;

    int n_cmp = 0;
    int n_bad = 0;

    i_mem_fetch_sched dut (
        .QClk              (QClk),
        .RstQnnnL          (RstQnnnL),
        .ThreadEnQ100H     (ThreadEnQ100H),
        .ThreadStallQ100H  (ThreadStallQ100H),
        .FetchHoldQ100H    (FetchHoldQ100H),
        .NextPcValidQ102H  (NextPcValidQ102H),
        .NextPcThreadQ102H (NextPcThreadQ102H),
        .NextPcQ102H       (NextPcQ102H),
        .PcQ100H           (PcQ100H),
        .RdEnableQ100H     (RdEnableQ100H),
        .FetchThreadQ100H  (FetchThreadQ100H),
        .InstValidQ101H    (InstValidQ101H),
        .InstThreadQ101H   (InstThreadQ101H),
        .InstPcQ101H       (InstPcQ101H),
        .FetchCntQ101H     (FetchCntQ101H)
    );

    always #5 QClk = ~QClk;

    task automatic step();
        @(posedge QClk);
        #1;
    endtask

    task automatic upd(input logic [1:0] t, input logic [31:0] p);
        NextPcValidQ102H  = 1'b1;
        NextPcThreadQ102H = t;
        NextPcQ102H       = p;
    endtask

    task automatic test_reset();
        step();
        ThreadEnQ100H = 4'hF;
        #1;
        n_cmp++;
        if ({RdEnableQ100H, FetchThreadQ100H, PcQ100H} !== {1'b0, 2'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_q100 got rd=%0b th=%0d pc=%h want 0/0/0",
                     RdEnableQ100H, FetchThreadQ100H, PcQ100H);
        end
        n_cmp++;
        if ({InstValidQ101H, InstThreadQ101H, InstPcQ101H, FetchCntQ101H} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset_q101 got v=%0b th=%0d pc=%h cnt=%h want all 0",
                     InstValidQ101H, InstThreadQ101H, InstPcQ101H, FetchCntQ101H);
        end
        RstQnnnL = 1'b1;
        #1;
        n_cmp++;
        if ({RdEnableQ100H, FetchThreadQ100H, PcQ100H} !== {1'b1, 2'd0, 32'h000}) begin
            n_bad++;
            $display("FAIL first_grant got rd=%0b th=%0d pc=%h want 1/0/000",
                     RdEnableQ100H, FetchThreadQ100H, PcQ100H);
        end
        for (int k = 1; k < 4; k++) begin
            step();
            n_cmp++;
            if ({RdEnableQ100H, FetchThreadQ100H, PcQ100H, InstValidQ101H, InstThreadQ101H,
                 InstPcQ101H, FetchCntQ101H} !==
                {1'b1, 2'(k), 32'(k) * 32'h400, 1'b1, 2'(k - 1), 32'(k - 1) * 32'h400, 32'(k)}) begin
                n_bad++;
                $display("FAIL boot_grant%0d got rd=%0b th=%0d pc=%h iv=%0b ith=%0d ipc=%h cnt=%0d",
                         k, RdEnableQ100H, FetchThreadQ100H, PcQ100H, InstValidQ101H,
                         InstThreadQ101H, InstPcQ101H, FetchCntQ101H);
            end
        end
        step();
        n_cmp++;
        if ({RdEnableQ100H, InstThreadQ101H, InstPcQ101H, FetchCntQ101H} !==
            {1'b0, 2'd3, 32'hC00, 32'd4}) begin
            n_bad++;
            $display("FAIL boot_idle got rd=%0b ith=%0d ipc=%h cnt=%0d want 0/3/c00/4",
                     RdEnableQ100H, InstThreadQ101H, InstPcQ101H, FetchCntQ101H);
        end
        step();
        n_cmp++;
        if ({RdEnableQ100H, InstValidQ101H, PcQ100H} !== {1'b0, 1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL boot_idle2 got rd=%0b iv=%0b pc=%h want 0/0/0",
                     RdEnableQ100H, InstValidQ101H, PcQ100H);
        end
    endtask

    task automatic test_update();
        upd(2'd0, 32'h104);
        #1;
        n_cmp++;
        if (RdEnableQ100H !== 1'b0) begin
            n_bad++;
            $display("FAIL upd_pre got rd=%0b want 0", RdEnableQ100H);
        end
        step();
        NextPcValidQ102H = 1'b0;
        #1;
        n_cmp++;
        if ({RdEnableQ100H, FetchThreadQ100H, PcQ100H} !== {1'b1, 2'd0, 32'h104}) begin
            n_bad++;
            $display("FAIL upd_grant got rd=%0b th=%0d pc=%h want 1/0/104",
                     RdEnableQ100H, FetchThreadQ100H, PcQ100H);
        end
        step();
        n_cmp++;
        if ({InstValidQ101H, InstThreadQ101H, InstPcQ101H, RdEnableQ100H, FetchCntQ101H} !==
            {1'b1, 2'd0, 32'h104, 1'b0, 32'd5}) begin
            n_bad++;
            $display("FAIL upd_q101 got iv=%0b ith=%0d ipc=%h rd=%0b cnt=%0d want 1/0/104/0/5",
                     InstValidQ101H, InstThreadQ101H, InstPcQ101H, RdEnableQ100H, FetchCntQ101H);
        end
    endtask

    task automatic test_stall();
        logic [31:0] pcs [4];
        logic [1:0]  order [3];
        pcs[0] = 32'h200; pcs[1] = 32'h300; pcs[2] = 32'h500; pcs[3] = 32'h600;
        order[0] = 2'd2; order[1] = 2'd3; order[2] = 2'd0;
        FetchHoldQ100H   = 1'b1;
        ThreadStallQ100H = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            upd(2'(i), pcs[i]);
            step();
        end
        NextPcValidQ102H = 1'b0;
        FetchHoldQ100H   = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if ({RdEnableQ100H, FetchThreadQ100H, PcQ100H} !== {1'b1, order[j], pcs[order[j]]}) begin
                n_bad++;
                $display("FAIL stall_order%0d got rd=%0b th=%0d pc=%h want 1/%0d/%h",
                         j, RdEnableQ100H, FetchThreadQ100H, PcQ100H, order[j], pcs[order[j]]);
            end
            step();
        end
        n_cmp++;
        if (RdEnableQ100H !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_skip got rd=%0b th=%0d want rd 0", RdEnableQ100H, FetchThreadQ100H);
        end
        ThreadStallQ100H = 4'b0000;
        #1;
        n_cmp++;
        if ({RdEnableQ100H, FetchThreadQ100H, PcQ100H} !== {1'b1, 2'd1, 32'h300}) begin
            n_bad++;
            $display("FAIL stall_clear got rd=%0b th=%0d pc=%h want 1/1/300",
                     RdEnableQ100H, FetchThreadQ100H, PcQ100H);
        end
        step();
        n_cmp++;
        if ({RdEnableQ100H, FetchCntQ101H} !== {1'b0, 32'd9}) begin
            n_bad++;
            $display("FAIL stall_cnt got rd=%0b cnt=%0d want 0/9", RdEnableQ100H, FetchCntQ101H);
        end
    endtask

    task automatic test_hold();
        logic [31:0] pcs [4];
        logic [1:0]  order [4];
        pcs[0] = 32'h1000; pcs[1] = 32'h1100; pcs[2] = 32'h1200; pcs[3] = 32'h1300;
        order[0] = 2'd2; order[1] = 2'd3; order[2] = 2'd0; order[3] = 2'd1;
        FetchHoldQ100H = 1'b1;
        for (int i = 0; i < 4; i++) begin
            upd(2'(i), pcs[i]);
            step();
        end
        NextPcValidQ102H = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if ({RdEnableQ100H, PcQ100H, FetchCntQ101H} !== {1'b0, 32'd0, 32'd9}) begin
                n_bad++;
                $display("FAIL hold_cyc%0d got rd=%0b pc=%h cnt=%0d want 0/0/9",
                         c, RdEnableQ100H, PcQ100H, FetchCntQ101H);
            end
            step();
        end
        FetchHoldQ100H = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if ({RdEnableQ100H, FetchThreadQ100H, PcQ100H} !== {1'b1, order[j], pcs[order[j]]}) begin
                n_bad++;
                $display("FAIL hold_order%0d got rd=%0b th=%0d pc=%h want 1/%0d/%h",
                         j, RdEnableQ100H, FetchThreadQ100H, PcQ100H, order[j], pcs[order[j]]);
            end
            step();
        end
        n_cmp++;
        if ({RdEnableQ100H, FetchCntQ101H} !== {1'b0, 32'd13}) begin
            n_bad++;
            $display("FAIL hold_cnt got rd=%0b cnt=%0d want 0/13", RdEnableQ100H, FetchCntQ101H);
        end
    endtask

    task automatic test_same_edge();
        upd(2'd3, 32'h700);
        step();
        upd(2'd2, 32'h20B);
        #1;
        n_cmp++;
        if ({RdEnableQ100H, FetchThreadQ100H, PcQ100H} !== {1'b1, 2'd3, 32'h700}) begin
            n_bad++;
            $display("FAIL same_t3 got rd=%0b th=%0d pc=%h want 1/3/700",
                     RdEnableQ100H, FetchThreadQ100H, PcQ100H);
        end
        step();
        NextPcValidQ102H = 1'b0;
        #1;
        n_cmp++;
        if ({RdEnableQ100H, FetchThreadQ100H, PcQ100H, dut.in_flight[3], InstThreadQ101H, InstPcQ101H} !==
            {1'b1, 2'd2, 32'h208, 1'b1, 2'd3, 32'h700}) begin
            n_bad++;
            $display("FAIL same_edge got rd=%0b th=%0d pc=%h if3=%0b ith=%0d ipc=%h want 1/2/208/1/3/700",
                     RdEnableQ100H, FetchThreadQ100H, PcQ100H, dut.in_flight[3],
                     InstThreadQ101H, InstPcQ101H);
        end
        step();
        n_cmp++;
        if ({RdEnableQ100H, FetchCntQ101H} !== {1'b0, 32'd15}) begin
            n_bad++;
            $display("FAIL same_cnt got rd=%0b cnt=%0d want 0/15", RdEnableQ100H, FetchCntQ101H);
        end
    endtask

    task automatic test_reset_mid();
        force dut.fetch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt;
        #1;
        n_cmp++;
        if (FetchCntQ101H !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL preset_cnt got %h want ffffffff", FetchCntQ101H);
        end
        RstQnnnL         = 1'b0;
        ThreadEnQ100H    = 4'b1110;
        ThreadStallQ100H = 4'b0010;
        #1;
        n_cmp++;
        if ({RdEnableQ100H, PcQ100H, InstValidQ101H, FetchCntQ101H, dut.in_flight} !==
            {1'b0, 32'd0, 1'b0, 32'd0, 4'd0}) begin
            n_bad++;
            $display("FAIL mid_reset got rd=%0b pc=%h iv=%0b cnt=%h if=%b want 0/0/0/0/0000",
                     RdEnableQ100H, PcQ100H, InstValidQ101H, FetchCntQ101H, dut.in_flight);
        end
        step();
        RstQnnnL = 1'b1;
        #1;
        n_cmp++;
        if ({RdEnableQ100H, FetchThreadQ100H, PcQ100H} !== {1'b1, 2'd2, 32'h800}) begin
            n_bad++;
            $display("FAIL post_reset got rd=%0b th=%0d pc=%h want 1/2/800",
                     RdEnableQ100H, FetchThreadQ100H, PcQ100H);
        end
        step();
        n_cmp++;
        if ({RdEnableQ100H, FetchThreadQ100H, PcQ100H, FetchCntQ101H} !== {1'b1, 2'd3, 32'hC00, 32'd1}) begin
            n_bad++;
            $display("FAIL post_reset2 got rd=%0b th=%0d pc=%h cnt=%0d want 1/3/c00/1",
                     RdEnableQ100H, FetchThreadQ100H, PcQ100H, FetchCntQ101H);
        end
        step();
    endtask

    task automatic test_disable();
        ThreadEnQ100H = 4'b1010;
        step();
        ThreadEnQ100H = 4'b1110;
        #1;
        n_cmp++;
        if ({RdEnableQ100H, FetchThreadQ100H, PcQ100H} !== {1'b1, 2'd2, 32'h800}) begin
            n_bad++;
            $display("FAIL disable_regrant got rd=%0b th=%0d pc=%h want 1/2/800",
                     RdEnableQ100H, FetchThreadQ100H, PcQ100H);
        end
        step();
        n_cmp++;
        if ({RdEnableQ100H, FetchCntQ101H} !== {1'b0, 32'd3}) begin
            n_bad++;
            $display("FAIL disable_cnt got rd=%0b cnt=%0d want 0/3", RdEnableQ100H, FetchCntQ101H);
        end
    endtask

    task automatic test_wrap();
        force dut.fetch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt;
        ThreadEnQ100H = 4'b1111;
        #1;
        n_cmp++;
        if ({RdEnableQ100H, FetchThreadQ100H, PcQ100H, FetchCntQ101H} !==
            {1'b1, 2'd0, 32'h000, 32'hFFFF_FFFF}) begin
            n_bad++;
            $display("FAIL wrap_pre got rd=%0b th=%0d pc=%h cnt=%h want 1/0/000/ffffffff",
                     RdEnableQ100H, FetchThreadQ100H, PcQ100H, FetchCntQ101H);
        end
        step();
        n_cmp++;
        if (FetchCntQ101H !== 32'd0) begin
            n_bad++;
            $display("FAIL wrap_cnt got %h want 00000000", FetchCntQ101H);
        end
    endtask

    initial begin
        RstQnnnL          = 1'b0;
        ThreadEnQ100H     = 4'h0;
        ThreadStallQ100H  = 4'h0;
        FetchHoldQ100H    = 1'b0;
        NextPcValidQ102H  = 1'b0;
        NextPcThreadQ102H = 2'd0;
        NextPcQ102H       = 32'd0;
        test_reset();
        test_update();
        test_stall();
        test_hold();
        test_same_edge();
        test_reset_mid();
        test_disable();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i_mem_fetch_sched.md
I_MEM_FETCH_SCHED -- requirements
Module: i_mem_fetch_sched

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the reset PC of thread 0.
REQ-002 SHALL have parameter PC_STRIDE, default 32'h0000_0400, the reset-PC offset between threads; thread i resets to RESET_PC + i*PC_STRIDE.
REQ-003 SHALL have port QClk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RstQnnnL  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ThreadEnQ100H  in  4  per-thread enable.
REQ-006 SHALL have port ThreadStallQ100H  in  4  per-thread fetch-not-allowed this cycle.
REQ-007 SHALL have port FetchHoldQ100H  in  1  global hold; no fetch issued this cycle.
REQ-008 SHALL have port NextPcValidQ102H  in  1  PC update from pipeline is valid.
REQ-009 SHALL have port NextPcThreadQ102H  in  2  thread ID of the PC update.
REQ-010 SHALL have port NextPcQ102H  in  32  new PC for that thread.
REQ-011 SHALL have port PcQ100H  out  32  fetch address to instruction memory port A.
REQ-012 SHALL have port RdEnableQ100H  out  1  fetch read enable to port A.
REQ-013 SHALL have port FetchThreadQ100H  out  2  thread granted this cycle.
REQ-014 SHALL have port InstValidQ101H  out  1  instruction data on memory output is valid.
REQ-015 SHALL have port InstThreadQ101H  out  2  thread owning the Q101H instruction.
REQ-016 SHALL have port InstPcQ101H  out  32  PC of the Q101H instruction.
REQ-017 SHALL have port FetchCntQ101H  out  32  total issued fetches, free-running.

Function
REQ-018 SHALL hold per-thread state: PC[i] (32b, bits[1:0] always 0), InFlight[i] (1b), plus a 2b round-robin pointer LastGnt.
REQ-019 Thread i SHALL be eligible iff ThreadEn[i] & ~ThreadStall[i] & ~InFlight[i] & ~FetchHold.
REQ-020 Grant SHALL be combinational in Q100H: the first eligible thread searching LastGnt+1, +2, +3, +4 (mod 4); at most one grant per cycle.
REQ-021 On grant: RdEnableQ100H=1, FetchThreadQ100H=granted ID, PcQ100H=PC[granted]; next edge sets InFlight[granted]=1 and LastGnt=granted.
REQ-022 With no grant: RdEnableQ100H=0, PcQ100H=0, FetchThreadQ100H=0; LastGnt unchanged.
REQ-023 InstValidQ101H, InstThreadQ101H and InstPcQ101H SHALL be RdEnableQ100H, FetchThreadQ100H and PcQ100H registered by one cycle (matching the 1-cycle memory read latency).
REQ-024 A thread SHALL have at most one outstanding fetch; InFlight[i] clears only on NextPcValid for thread i or on ThreadEn[i]=0.
REQ-025 On NextPcValidQ102H: PC[NextPcThread] <= {NextPcQ102H[31:2],2'b00}; InFlight[NextPcThread] <= 0; applies even if that thread was not in flight (PC overwritten, flag stays 0).
REQ-026 Simultaneous update of thread X and grant of thread Y (X != Y): both take effect on the same edge.
REQ-027 An update for thread X in a cycle where X is eligible is impossible by construction (X is in flight); the grant decision SHALL use pre-update state.
REQ-028 ThreadEn[i]=0 SHALL clear InFlight[i] and hold PC[i]; a fetch already issued still produces its Q101H outputs.
REQ-029 FetchCntQ101H SHALL increment by 1 on every edge where RdEnableQ100H=1, and wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-030 While RstQnnnL=0: PC[i]=RESET_PC+i*PC_STRIDE, InFlight=0, LastGnt=3 (thread 0 wins first), all Q101H outputs and FetchCnt = 0.
REQ-031 Q100H outputs SHALL be 0 during reset regardless of inputs.
REQ-032 Reset asserted mid-operation SHALL discard all outstanding fetches; the first grant after deassertion goes to the lowest enabled unstalled thread.

Verification
REQ-033 Reset, all enabled, no stall -> cycle 1 grants T0 PC=0x000, T1 0x400, T2 0x800, T3 0xC00, then RdEnable=0 until updates arrive.
REQ-034 T0 NextPc=0x104 while T1..T3 in flight -> next cycle grants T0 with PcQ100H=0x104; InstPcQ101H=0x104, InstThread=0 one cycle later.
REQ-035 ThreadStall=4'b0010, all free, LastGnt=0 -> grant order T2, T3, T0; T1 skipped; T1 granted first once stall clears with LastGnt=0.
REQ-036 FetchHold=1 for 3 cycles with all eligible -> RdEnable=0, FetchCnt unchanged, LastGnt held; first grant after hold follows LastGnt.
REQ-037 NextPc for T2 (0x20B) on the same edge as grant of T3 -> PC[2]=0x208, InFlight[2]=0, InFlight[3]=1.
REQ-038 Reset pulse while 4 fetches are in flight and FetchCnt=0xFFFF_FFFF -> all state to reset values; with FetchCnt preset by force to 0xFFFF_FFFF and no reset, one fetch wraps it to 0.
